m_store_buffer: RTL and testbench

//  M-stage store buffer: takes sw/sh/sb requests, generates lane byte-enables and lane-aligned

---
 rtl/m_store_buffer.sv | 168 ++++++++++++++++
 tb/tb_m_store_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns sw/sh/sb stores into memory lanes, queues them in a
// DEPTH-entry FIFO with optional same-word merging into the youngest entry, and drains over valid/ready.
module m_store_buffer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 4,
    parameter bit MERGE_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 st_size,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_misalign,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_byteen,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int B  = DATA_W / 8;
    localparam int LB = $clog2(B);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_W    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_B    = 2'b11;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(B - 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [B-1:0]      r_be   [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [LB-1:0]     w_off;
    logic [ADDR_W-1:0] w_st_word;
    logic [ADDR_W-1:0] w_ld_word;
    logic              w_misaligned;
    logic [B-1:0]      w_base;
    logic [B-1:0]      w_be;
    logic [DATA_W-1:0] w_rep;
    logic [DATA_W-1:0] w_lane_data;
    logic [DATA_W-1:0] w_bit_mask;
    logic [PW-1:0]     w_youngest;
    logic              w_pop;
    logic              w_merge_cond;
    logic              w_accept;
    logic              w_push;
    logic              w_do_merge;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lane alignment: replicate the sized datum across the word, then keep only enabled lanes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_misaligned = 1'b0;
        w_base       = '0;
        w_rep        = '0;
        w_off        = st_addr[LB-1:0];
        w_st_word    = st_addr & ~OFF_MASK;
        w_ld_word    = ld_addr & ~OFF_MASK;
        case (st_size)
            SZ_W: begin
                w_misaligned = (w_off[1:0] != 2'b00);
                w_base       = B'(4'b1111);
                w_rep        = {(B/4){st_data}};
            end
            SZ_H: begin
                w_misaligned = w_off[0];
                w_base       = B'(2'b11);
                w_rep        = {(B/2){st_data[15:0]}};
            end
            SZ_B: begin
                w_base       = B'(1'b1);
                w_rep        = {B{st_data[7:0]}};
            end
            default: ;
        endcase
        w_be = w_base << w_off;
        for (int i = 0; i < B; i++) begin
            w_bit_mask[8*i +: 8]  = {8{w_be[i]}};
            w_lane_data[8*i +: 8] = w_be[i] ? w_rep[8*i +: 8] : 8'h00;
        end
    end

    assign w_youngest = (r_tail == '0) ? PW'(DEPTH - 1) : r_tail - 1'b1;
    assign mem_valid  = (r_count != '0);
    assign w_pop      = mem_valid & mem_ready;
    assign empty      = (r_count == '0);
    assign full       = (r_count == CW'(DEPTH));
    assign count      = r_count;

    // The youngest entry cannot take a merge when it is also the head being popped this cycle.
    assign w_merge_cond = MERGE_EN && (r_count != '0) && (w_st_word == r_addr[w_youngest])
                          && !((w_youngest == r_head) && w_pop);

    assign st_ready    = !full | w_merge_cond;
    assign st_misalign = st_valid & w_misaligned;
    assign w_accept    = st_valid & st_ready & !w_misaligned & (st_size != SZ_NONE);
    assign w_push      = w_accept & !w_merge_cond;
    assign w_do_merge  = w_accept & w_merge_cond;

    assign mem_addr   = r_addr[r_head];
    assign mem_wdata  = r_data[r_head];
    assign mem_byteen = r_be[r_head];

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == w_ld_word)) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: entry storage is reset too, because mem_* read the head entry directly and must be 0 in reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= w_st_word;
                r_data[r_tail] <= w_lane_data;
                r_be[r_tail]   <= w_be;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= f_inc(r_tail);
            end
            if (w_do_merge) begin
                r_be[w_youngest]   <= r_be[w_youngest] | w_be;
                r_data[w_youngest] <= (r_data[w_youngest] & ~w_bit_mask) | w_lane_data;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= f_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer: a vector table for the 32-bit buffer plus hand sequences
// for full-with-pop, asynchronous reset mid-drain, and the 64-bit lane layout.
module tb_m_store_buffer;

    localparam logic [1:0] NO = 2'b00;
    localparam logic [1:0] SW = 2'b01;
    localparam logic [1:0] SH = 2'b10;
    localparam logic [1:0] SB = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        st_valid, st_ready, st_misalign, ld_hit, mem_valid, mem_ready, empty, full;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_data, ld_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic [2:0]  count;

    logic        st_valid_64, st_ready_64, st_misalign_64, ld_hit_64, mem_valid_64, mem_ready_64;
    logic        empty_64, full_64;
    logic [1:0]  st_size_64;
    logic [31:0] st_addr_64, st_data_64, ld_addr_64, mem_addr_64;
    logic [63:0] mem_wdata_64;
    logic [7:0]  mem_byteen_64;
    logic [2:0]  count_64;

    m_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MERGE_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size), .st_addr(st_addr),
        .st_data(st_data), .st_misalign(st_misalign), .ld_addr(ld_addr), .ld_hit(ld_hit),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .count(count), .empty(empty), .full(full)
    );

    m_store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4), .MERGE_EN(1'b1)) dut64 (
        .clk(clk), .reset(reset),
        .st_valid(st_valid_64), .st_ready(st_ready_64), .st_size(st_size_64), .st_addr(st_addr_64),
        .st_data(st_data_64), .st_misalign(st_misalign_64), .ld_addr(ld_addr_64), .ld_hit(ld_hit_64),
        .mem_valid(mem_valid_64), .mem_ready(mem_ready_64), .mem_addr(mem_addr_64),
        .mem_wdata(mem_wdata_64), .mem_byteen(mem_byteen_64), .count(count_64),
        .empty(empty_64), .full(full_64)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ld;
        logic        mr;
        logic        e_rdy;
        logic        e_mis;
        logic        e_hit;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_mv;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] ld, input logic mr);
        st_valid  = v;
        st_size   = sz;
        st_addr   = a;
        st_data   = d;
        ld_addr   = ld;
        mem_ready = mr;
    endtask

    task automatic drive64(input logic v, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic mr);
        st_valid_64  = v;
        st_size_64   = sz;
        st_addr_64   = a;
        st_data_64   = d;
        ld_addr_64   = 32'h0;
        mem_ready_64 = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                v     sz  addr          data          ld            mr    rdy   mis   hit   cnt   full  mv    addr          wdata         be
        vecs[0]  = '{1'b1, SB, 32'h0000_1003, 32'h0000_00AB, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0000_1000, 32'hAB00_0000, 4'b1000};
        vecs[1]  = '{1'b0, NO, 32'h0,        32'h0,        32'h0000_1002, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[2]  = '{1'b1, SH, 32'h0000_2000, 32'hFFFF_1234, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_1234, 4'b0011};
        vecs[3]  = '{1'b1, SB, 32'h0000_2002, 32'h0000_0056, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0000_2000, 32'h0056_1234, 4'b0111};
        vecs[4]  = '{1'b0, NO, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[5]  = '{1'b1, SW, 32'h0000_0000, 32'h1111_1111, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[6]  = '{1'b1, SW, 32'h0000_0004, 32'h2222_2222, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[7]  = '{1'b1, SW, 32'h0000_0008, 32'h3333_3333, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[8]  = '{1'b1, SW, 32'h0000_000C, 32'h4444_4444, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[9]  = '{1'b1, SW, 32'h0000_0010, 32'h5555_5555, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[10] = '{1'b1, SB, 32'h0000_000D, 32'h0000_00EE, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 32'h0,        32'h1111_1111, 4'b1111};
        vecs[11] = '{1'b0, NO, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 4'b1111};
        vecs[12] = '{1'b0, NO, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 4'b1111};
        vecs[13] = '{1'b1, SW, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0000_000E, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 32'h0000_000C, 32'h4444_EE44, 4'b1111};
        vecs[14] = '{1'b0, NO, 32'h0,        32'h0,        32'h0000_0040, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'b1111};
        vecs[15] = '{1'b0, NO, 32'h0,        32'h0,        32'h0000_0040, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[16] = '{1'b1, SW, 32'h0000_3002, 32'h1234_5678, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[17] = '{1'b1, SH, 32'h0000_3001, 32'h0000_BEEF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[18] = '{1'b1, SB, 32'h0000_3001, 32'h0000_0077, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_7700, 4'b0010};
        vecs[19] = '{1'b1, NO, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_7700, 4'b0010};
        vecs[20] = '{1'b1, SB, 32'h0000_3000, 32'h0000_0099, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_0099, 4'b0001};
        vecs[21] = '{1'b0, NO, 32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};
        vecs[22] = '{1'b0, SW, 32'h0000_3002, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000};

        reset = 1'b1;
        drive(1'b0, NO, 32'h0, 32'h0, 32'h0, 1'b0);
        drive64(1'b0, NO, 32'h0, 32'h0, 1'b0);
        #12;
        check("reset count", 64'(count), 64'd0);
        check("reset empty", 64'(empty), 64'd1);
        check("reset full", 64'(full), 64'd0);
        check("reset mem_valid", 64'(mem_valid), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        check("reset mem_wdata", 64'(mem_wdata), 64'd0);
        check("reset mem_byteen", 64'(mem_byteen), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].sz, vecs[i].addr, vecs[i].data, vecs[i].ld, vecs[i].mr);
            #1;
            check($sformatf("v%0d st_ready", i), 64'(st_ready), 64'(vecs[i].e_rdy));
            check($sformatf("v%0d st_misalign", i), 64'(st_misalign), 64'(vecs[i].e_mis));
            check($sformatf("v%0d ld_hit", i), 64'(ld_hit), 64'(vecs[i].e_hit));
            tick();
            check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            check($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].e_cnt == 3'd0));
            check($sformatf("v%0d full", i), 64'(full), 64'(vecs[i].e_full));
            check($sformatf("v%0d mem_valid", i), 64'(mem_valid), 64'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                check($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_addr));
                check($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wd));
                check($sformatf("v%0d mem_byteen", i), 64'(mem_byteen), 64'(vecs[i].e_be));
            end
        end

        // Fill to full, then a pop in the same cycle must not open the door for a new word.
        drive(1'b1, SW, 32'h0000_0100, 32'hA0A0_A0A0, 32'h0, 1'b0); tick();
        drive(1'b1, SW, 32'h0000_0104, 32'hB1B1_B1B1, 32'h0, 1'b0); tick();
        drive(1'b1, SW, 32'h0000_0108, 32'hC2C2_C2C2, 32'h0, 1'b0); tick();
        drive(1'b1, SW, 32'h0000_010C, 32'hD3D3_D3D3, 32'h0, 1'b0); tick();
        check("fill full", 64'(full), 64'd1);
        drive(1'b1, SW, 32'h0000_0200, 32'hE4E4_E4E4, 32'h0, 1'b1);
        #1;
        check("full+pop st_ready", 64'(st_ready), 64'd0);
        tick();
        check("full+pop count", 64'(count), 64'd3);
        check("full+pop head", 64'(mem_addr), 64'h104);
        check("full+pop wdata", 64'(mem_wdata), 64'hB1B1_B1B1);

        // Asynchronous reset between edges with three entries pending.
        drive(1'b0, NO, 32'h0, 32'h0, 32'h0000_0104, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async rst mem_valid", 64'(mem_valid), 64'd0);
        check("async rst count", 64'(count), 64'd0);
        check("async rst empty", 64'(empty), 64'd1);
        check("async rst full", 64'(full), 64'd0);
        check("async rst mem_addr", 64'(mem_addr), 64'd0);
        check("async rst ld_hit", 64'(ld_hit), 64'd0);
        #1;
        reset = 1'b0;
        tick();
        drive(1'b1, SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1'b0);
        tick();
        check("post rst count", 64'(count), 64'd1);
        check("post rst mem_addr", 64'(mem_addr), 64'h1000);
        check("post rst mem_wdata", 64'(mem_wdata), 64'hAB00_0000);
        check("post rst mem_byteen", 64'(mem_byteen), 64'b1000);
        drive(1'b0, NO, 32'h0, 32'h0, 32'h0, 1'b0);

        // 64-bit lane layout and merging across the upper half.
        drive64(1'b1, SB, 32'h0000_0005, 32'h0000_00CD, 1'b0);
        #1;
        check("d64 sb misalign", 64'(st_misalign_64), 64'd0);
        tick();
        check("d64 sb count", 64'(count_64), 64'd1);
        check("d64 sb mem_addr", 64'(mem_addr_64), 64'h0);
        check("d64 sb byteen", 64'(mem_byteen_64), 64'h20);
        check("d64 sb wdata", mem_wdata_64, 64'h0000_CD00_0000_0000);
        drive64(1'b1, SW, 32'h0000_0004, 32'h1234_5678, 1'b0);
        tick();
        check("d64 sw merge count", 64'(count_64), 64'd1);
        check("d64 sw merge byteen", 64'(mem_byteen_64), 64'hF0);
        check("d64 sw merge wdata", mem_wdata_64, 64'h1234_5678_0000_0000);
        drive64(1'b1, SH, 32'h0000_0006, 32'h0000_BEEF, 1'b0);
        tick();
        check("d64 sh merge wdata", mem_wdata_64, 64'hBEEF_5678_0000_0000);
        drive64(1'b1, SW, 32'h0000_0002, 32'h0, 1'b0);
        #1;
        check("d64 sw misalign", 64'(st_misalign_64), 64'd1);
        drive64(1'b0, NO, 32'h0, 32'h0, 1'b0);
        tick();
        check("d64 final count", 64'(count_64), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
